// File: rtl/flo_rx_arbiter.sv
// rtl/flo_rx_arbiter.sv - round-robin RX FIFO readout arbiter with settle-timed read pulses
// Define FLO_RX_ARB_URGENT_EN to let channels at or above URGENT_THRESH pre-empt round-robin order.
module flo_rx_arbiter #(
  parameter int N_CH          = 2,
  parameter int WIDTH         = 24,
  parameter int LOCS_BITS     = 14,
  parameter int BURST         = 4,
  parameter int SETTLE        = 3,
  parameter int URGENT_THRESH = 12288
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable_i,
  input  logic [N_CH*WIDTH-1:0]         fifo_data_i,
  input  logic [N_CH-1:0]               fifo_valid_i,
  input  logic [N_CH*LOCS_BITS-1:0]     fifo_locs_i,
  output logic [N_CH-1:0]               fifo_read_o,
  output logic [WIDTH+$clog2(N_CH)-1:0] data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic                          busy_o,
  output logic [$clog2(N_CH)-1:0]       grant_o,
  output logic [31:0]                   word_cnt_o
);

  localparam int CW = $clog2(N_CH);
  localparam int SW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [LOCS_BITS-1:0] L_THRESH = LOCS_BITS'(URGENT_THRESH);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_WAIT} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CW-1:0]         r_rr_ptr;
  logic [CW-1:0]         r_grant;
  logic [7:0]            r_burst_cnt;
  logic [SW-1:0]         r_settle_cnt;
  logic [N_CH-1:0]       r_read;
  logic [WIDTH+CW-1:0]   r_data;
  logic                  r_valid;
  logic [31:0]           r_word_cnt;

  logic                  w_rr_any;
  logic [CW-1:0]         w_rr_sel;
  int                    w_idx;
  logic                  w_grant_any;
  logic [CW-1:0]         w_grant_ch;
  logic                  w_cur_valid;
  logic                  w_rr_cont;
  logic                  w_continue;
  logic                  w_rr_adv;
  logic                  w_slot_free;
  logic                  w_settle_done;
  logic                  w_grant;
  logic                  w_load;
  logic                  w_exit;
  logic [CW-1:0]         w_rr_next;

  // Scan downward so the channel closest to r_rr_ptr is the last one written.
  always_comb begin
    w_rr_any = 1'b0;
    w_rr_sel = '0;
    w_idx    = 0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      w_idx = int'(r_rr_ptr) + i;
      if (w_idx >= N_CH) w_idx = w_idx - N_CH;
      if (fifo_valid_i[w_idx]) begin
        w_rr_any = 1'b1;
        w_rr_sel = CW'(w_idx);
      end
    end
  end

  assign w_cur_valid   = fifo_valid_i[r_grant];
  assign w_rr_cont     = enable_i && (r_burst_cnt < 8'(BURST)) && w_cur_valid;
  assign w_slot_free   = !r_valid || ready_i;
  assign w_settle_done = (r_settle_cnt <= SW'(1));
  assign w_rr_next     = (r_grant == CW'(N_CH - 1)) ? '0 : r_grant + CW'(1);

`ifdef FLO_RX_ARB_URGENT_EN
  logic          r_urgent;
  logic          w_urg_any;
  logic [CW-1:0] w_urg_sel;
  logic          w_urg_keep;

  always_comb begin
    w_urg_any = 1'b0;
    w_urg_sel = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (fifo_valid_i[i] && (fifo_locs_i[i*LOCS_BITS +: LOCS_BITS] >= L_THRESH)) begin
        w_urg_any = 1'b1;
        w_urg_sel = CW'(i);
      end
    end
  end

  assign w_urg_keep  = fifo_locs_i[r_grant*LOCS_BITS +: LOCS_BITS] >= L_THRESH;
  assign w_grant_any = w_rr_any | w_urg_any;
  assign w_grant_ch  = w_urg_any ? w_urg_sel : w_rr_sel;
  assign w_continue  = r_urgent ? (enable_i && w_cur_valid && w_urg_keep) : w_rr_cont;
  assign w_rr_adv    = !r_urgent;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_urgent <= 1'b0;
    else if (w_grant) r_urgent <= w_urg_any;
  end
`else
  logic w_unused;

  assign w_grant_any = w_rr_any;
  assign w_grant_ch  = w_rr_sel;
  assign w_continue  = w_rr_cont;
  assign w_rr_adv    = 1'b1;
  assign w_unused    = ^{fifo_locs_i, L_THRESH};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (enable_i && w_grant_any) w_state_nxt = S_XFER;
      S_XFER:  if (w_slot_free) w_state_nxt = S_WAIT;
      S_WAIT:  if (w_settle_done) w_state_nxt = w_continue ? S_XFER : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_grant = (r_state == S_IDLE) && enable_i && w_grant_any;
    w_load  = (r_state == S_XFER) && w_slot_free;
    w_exit  = (r_state == S_WAIT) && w_settle_done && !w_continue;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr     <= '0;
      r_grant      <= '0;
      r_burst_cnt  <= '0;
      r_settle_cnt <= '0;
      r_read       <= '0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_word_cnt   <= '0;
    end else begin
      if (w_grant) begin
        r_grant     <= w_grant_ch;
        r_burst_cnt <= '0;
      end
      // A new load always wins over a same-edge handshake clearing valid.
      if (w_load) begin
        r_data       <= {r_grant, fifo_data_i[r_grant*WIDTH +: WIDTH]};
        r_valid      <= 1'b1;
        r_settle_cnt <= SW'(SETTLE);
        if (r_burst_cnt != 8'hFF) r_burst_cnt <= r_burst_cnt + 8'd1;
      end else if (r_valid && ready_i) begin
        r_valid <= 1'b0;
      end
      r_read <= w_load ? (N_CH'(1) << r_grant) : '0;
      if (r_state == S_WAIT) r_settle_cnt <= r_settle_cnt - SW'(1);
      if (r_valid && ready_i) r_word_cnt <= r_word_cnt + 32'd1;
      if (w_exit && w_rr_adv) r_rr_ptr <= w_rr_next;
    end
  end

  assign fifo_read_o = r_read;
  assign data_o      = r_data;
  assign valid_o     = r_valid;
  assign busy_o      = (r_state != S_IDLE);
  assign grant_o     = r_grant;
  assign word_cnt_o  = r_word_cnt;

endmodule

// File: tb/tb_flo_rx_arbiter.sv
// tb/tb_flo_rx_arbiter.sv - scoreboard bench for flo_rx_arbiter with behavioural RX FIFO models
module tb_flo_rx_arbiter;

  localparam int N_CH      = 2;
  localparam int WIDTH     = 24;
  localparam int LOCS_BITS = 14;
  localparam int BURST     = 4;
  localparam int SETTLE    = 3;
  localparam int CW        = 1;
  localparam int DW        = WIDTH + CW;
  localparam int DEPTH     = 128;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      enable_i;
  logic                      ready_i;
  logic [N_CH*WIDTH-1:0]     fifo_data_i;
  logic [N_CH-1:0]           fifo_valid_i;
  logic [N_CH*LOCS_BITS-1:0] fifo_locs_i;
  logic [N_CH-1:0]           fifo_read_o;
  logic [DW-1:0]             data_o;
  logic                      valid_o;
  logic                      busy_o;
  logic [CW-1:0]             grant_o;
  logic [31:0]               word_cnt_o;

  flo_rx_arbiter #(
    .N_CH(N_CH), .WIDTH(WIDTH), .LOCS_BITS(LOCS_BITS),
    .BURST(BURST), .SETTLE(SETTLE), .URGENT_THRESH(12288)
  ) dut (
    .clk(clk), .rst(rst), .enable_i(enable_i),
    .fifo_data_i(fifo_data_i), .fifo_valid_i(fifo_valid_i), .fifo_locs_i(fifo_locs_i),
    .fifo_read_o(fifo_read_o), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .busy_o(busy_o), .grant_o(grant_o), .word_cnt_o(word_cnt_o)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] mem [N_CH][DEPTH];
  int head [N_CH] = '{default: 0};
  int tail [N_CH] = '{default: 0};
  int locs_base [N_CH] = '{default: 0};

  always @(posedge clk)
    for (int c = 0; c < N_CH; c++)
      if (fifo_read_o[c] && head[c] < tail[c]) head[c] <= head[c] + 1;

  always_comb begin
    fifo_data_i  = '0;
    fifo_valid_i = '0;
    fifo_locs_i  = '0;
    for (int c = 0; c < N_CH; c++) begin
      fifo_valid_i[c] = head[c] < tail[c];
      fifo_data_i[c*WIDTH +: WIDTH] = mem[c][head[c] % DEPTH];
      fifo_locs_i[c*LOCS_BITS +: LOCS_BITS] = LOCS_BITS'(locs_base[c] + tail[c] - head[c]);
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic fifo_push(input int c, input logic [WIDTH-1:0] d);
    mem[c][tail[c]] = d;
    tail[c]++;
  endtask

  // Reference arbitration over the current FIFO contents: bursts of up to BURST, round-robin.
  task automatic sb_plan(input int rr_start);
    int cnt [N_CH];
    int pos [N_CH];
    int rr;
    int sel;
    rr = rr_start;
    for (int c = 0; c < N_CH; c++) begin
      pos[c] = head[c];
      cnt[c] = tail[c] - head[c];
    end
    while (1) begin
      sel = -1;
      for (int i = 0; i < N_CH; i++)
        if (sel < 0 && cnt[(rr + i) % N_CH] > 0) sel = (rr + i) % N_CH;
      if (sel < 0) break;
      for (int k = 0; k < BURST && cnt[sel] > 0; k++) begin
        sb_q.push_back({CW'(sel), mem[sel][pos[sel]]});
        pos[sel]++;
        cnt[sel]--;
      end
      rr = (sel + 1) % N_CH;
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] prev_data;
  logic          prev_hold = 1'b0;
  logic [31:0]   m_exp;
  int            last_rd = -1;
  int            n_pulses = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
      last_rd   = -1;
    end else begin
      if (prev_hold) chk("hold_data", 32'(data_o), 32'(prev_data));
      if (valid_o && ready_i) begin
        m_exp = (sb_q.size() != 0) ? 32'(sb_q.pop_front()) : '1;
        chk("sb_data", 32'(data_o), m_exp);
      end
      if (fifo_read_o != '0) begin
        n_pulses++;
        chk("rd_onehot", 32'($onehot(fifo_read_o)), 32'd1);
        if (last_rd >= 0) chk("rd_gap", 32'((cyc - last_rd) >= SETTLE + 1), 32'd1);
        last_rd = cyc;
      end
      prev_hold = valid_o && !ready_i;
      prev_data = data_o;
    end
  end

  task automatic do_reset();
    rst      = 1'b1;
    enable_i = 1'b0;
    ready_i  = 1'b1;
    for (int c = 0; c < N_CH; c++) begin
      tail[c]      = head[c];
      locs_base[c] = 0;
    end
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int t;
    t = 0;
    while ((sb_q.size() != 0 || busy_o || valid_o) && t < budget) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk({tag, "_left"}, 32'(sb_q.size()), 32'd0);
    chk({tag, "_tmo"}, 32'(t >= budget), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_read"}, 32'(fifo_read_o), 32'd0);
    chk({tag, "_data"}, 32'(data_o), 32'd0);
    chk({tag, "_valid"}, 32'(valid_o), 32'd0);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_grant"}, 32'(grant_o), 32'd0);
    chk({tag, "_wcnt"}, word_cnt_o, 32'd0);
  endtask

  initial begin
    int t;
    int p0;
    logic [DW-1:0] d0;

    rst = 1'b1;
    enable_i = 1'b0;
    ready_i = 1'b1;
    @(posedge clk);
    #1 check_zero("rst");

    // Single channel, 6 words: burst of 4, back to IDLE, regrant for 2.
    do_reset();
    for (int i = 1; i <= 6; i++) fifo_push(0, WIDTH'(i));
    sb_plan(0);
    enable_i = 1'b1;
    drain("t1", 300);
    chk("t1_wcnt", word_cnt_o, 32'd6);
    repeat (4) @(posedge clk);
    #1 chk("t1_idle_busy", 32'(busy_o), 32'd0);

    // Both channels loaded: alternating bursts of BURST.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      fifo_push(0, WIDTH'(32'h100 + i));
      fifo_push(1, WIDTH'(32'h200 + i));
    end
    sb_plan(0);
    enable_i = 1'b1;
    drain("t2", 600);
    chk("t2_wcnt", word_cnt_o, 32'd16);

    // Downstream stall after the first word.
    do_reset();
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) fifo_push(0, WIDTH'(32'h300 + i));
    for (int i = 0; i < 2; i++) fifo_push(1, WIDTH'(32'h400 + i));
    sb_plan(0);
    enable_i = 1'b1;
    t = 0;
    while (!valid_o && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("t3_first_tmo", 32'(t >= 20), 32'd0);
    @(posedge clk);
    #1;
    p0 = n_pulses;
    d0 = data_o;
    repeat (10) @(posedge clk);
    #1;
    chk("t3_stall_rd", 32'(n_pulses - p0), 32'd0);
    chk("t3_stall_data", 32'(data_o), 32'(d0));
    ready_i = 1'b1;
    drain("t3", 400);
    chk("t3_wcnt", word_cnt_o, 32'd5);

    // Reset while a popped ch1 word sits in data_o; restart must begin at ch0.
    do_reset();
    fifo_push(0, 24'h0000A1);
    for (int i = 1; i <= 3; i++) fifo_push(1, WIDTH'(32'hB0 + i));
    sb_plan(0);
    enable_i = 1'b1;
    t = 0;
    while (grant_o != 1'b1 && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk("t4_grant_tmo", 32'(t >= 60), 32'd0);
    ready_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t4_pre_valid", 32'(valid_o), 32'd1);
    rst = 1'b1;
    sb_q.delete();
    @(posedge clk);
    #1 check_zero("t4_rst");
    fifo_push(0, 24'h0000A2);
    sb_plan(0);
    rst = 1'b0;
    ready_i = 1'b1;
    drain("t4", 400);
    chk("t4_wcnt", word_cnt_o, 32'd3);

    // Disabled arbiter stays idle; enabling yields a word two edges later.
    do_reset();
    fifo_push(0, 24'h00C001);
    fifo_push(0, 24'h00C002);
    sb_plan(0);
    p0 = n_pulses;
    repeat (8) @(posedge clk);
    #1;
    chk("t5_dis_busy", 32'(busy_o), 32'd0);
    chk("t5_dis_rd", 32'(n_pulses - p0), 32'd0);
    enable_i = 1'b1;
    @(posedge clk);
    #1 chk("t5_lat1", 32'(valid_o), 32'd0);
    @(posedge clk);
    #1 chk("t5_lat2", 32'(valid_o), 32'd1);
    drain("t5", 200);

`ifdef FLO_RX_ARB_URGENT_EN
    // Urgent ch1 pre-empts ch0 and drains until its fill level drops below threshold.
    do_reset();
    locs_base[1] = 12284;
    for (int i = 0; i < 2; i++) fifo_push(0, WIDTH'(32'hD00 + i));
    for (int i = 0; i < 16; i++) fifo_push(1, WIDTH'(32'hE00 + i));
    for (int i = 0; i < 13; i++) sb_q.push_back({1'b1, mem[1][head[1] + i]});
    for (int i = 0; i < 2; i++) sb_q.push_back({1'b0, mem[0][head[0] + i]});
    for (int i = 13; i < 16; i++) sb_q.push_back({1'b1, mem[1][head[1] + i]});
    enable_i = 1'b1;
    drain("t6", 600);
    chk("t6_wcnt", word_cnt_o, 32'd18);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/flo_rx_arbiter.md
Name: flo_rx_arbiter

Overview:
Round-robin readout controller that drains N_CH RX FIFOs (flofifo instances, valid/read handshake) into a single valid/ready output stream toward the host bus bridge.
Sequences each FIFO read, including the settle time the FIFO needs between reads, and limits each grant to a burst of at most BURST words so that no channel starves.
Tags every output word with its source channel index.

Parameters:
N_CH, 2, number of RX FIFO channels (2..8)
WIDTH, 24, FIFO data width
LOCS_BITS, 14, width of each FIFO fill-level input
BURST, 4, maximum words read per grant (1..255)
SETTLE, 3, idle cycles after each read pulse before the granted FIFO's valid is trusted again (≥3 for flofifo)
URGENT_THRESH, 12288, fill level that marks a channel urgent (used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
enable_i  in  1  arbiter enable; low = finish the current word, then stop granting
fifo_data_i  in  N_CH*WIDTH  concatenated FIFO data_o, channel 0 in LSBs
fifo_valid_i  in  N_CH  FIFO valid_o per channel
fifo_locs_i  in  N_CH*LOCS_BITS  FIFO locs_o per channel
fifo_read_o  out  N_CH  one-cycle read pulse per channel (FIFO read_i)
data_o  out  WIDTH+$clog2(N_CH)  {channel index, sample}
valid_o  out  1  output word valid
ready_i  in  1  downstream accepts word when valid_o && ready_i
busy_o  out  1  state != IDLE
grant_o  out  $clog2(N_CH)  currently or last granted channel
word_cnt_o  out  32  total words emitted, wraps at 2^32

Behaviour:
- Reset values (async on rst): fifo_read_o=0, data_o=0, valid_o=0, busy_o=0, grant_o=0, word_cnt_o=0. Internal state: state=IDLE, rr_ptr=0, burst_cnt=0, settle_cnt=0.
- Channel search order starts at rr_ptr and proceeds upward, wrapping modulo N_CH.
- IDLE: if enable_i and any fifo_valid_i bit is set, grant the first valid channel in search order. On the next edge: grant_o<=g, burst_cnt<=0, state<=XFER.
- XFER: the output slot is free when !valid_o || ready_i. When the slot is free, on one edge: data_o<={g, fifo_data_i[g]}, valid_o<=1, fifo_read_o[g]<=1 for exactly 1 cycle, burst_cnt++, settle_cnt<=SETTLE, state<=WAIT. When the slot is not free, stay in XFER with no read pulse.
- WAIT: decrement settle_cnt each cycle. At 0, go back to XFER if enable_i && burst_cnt<BURST && fifo_valid_i[g]. Otherwise go to IDLE with rr_ptr<=(g+1) mod N_CH.
- Latency: valid_i seen in IDLE at edge k gives data_o/valid_o at edge k+2. Per-channel throughput is 1 word per SETTLE+1 cycles.
- Output register:
  - valid_o clears on valid_o && ready_i unless a new word loads on the same edge.
  - data_o is held stable while valid_o && !ready_i.
  - word_cnt_o increments on each valid_o && ready_i.
- fifo_read_o is one-hot or zero, never asserted for 2 consecutive cycles, and never asserted outside the XFER→WAIT edge.
- enable_i falling during WAIT: the burst ends and the arbiter returns to IDLE. Any word already in data_o is still delivered.
- All fifo_valid_i low in IDLE: stay in IDLE with busy_o=0.
- Granted channel's valid drops mid-burst: the burst ends early and rr_ptr advances.
- Reset mid-operation: a word held in data_o, already popped from its FIFO, is discarded. A read pulse in flight is cut.

Optional Feature:
FLO_RX_ARB_URGENT_EN
- Defined: in IDLE, a channel with fifo_locs_i >= URGENT_THRESH and valid set wins over round-robin order; among several urgent channels, the lowest index wins. An urgent grant ignores BURST and continues while the channel stays urgent and valid. rr_ptr is not advanced after an urgent grant.
- Undefined: pure round-robin; fifo_locs_i is unused and URGENT_THRESH is ignored.

Test Plan:
- N_CH=2, ch0 holds 6 words (0x000001..0x000006), ready_i=1. Required: ch0 emits 4 words tagged 0, then the arbiter returns to IDLE, regrants ch0 (ch1 empty), and emits 2 more; word_cnt_o=6; each fifo_read_o pulse is ≥SETTLE+1 cycles apart.
- Both channels hold 8 words each, BURST=4. Required output channel order: 0,0,0,0,1,1,1,1,0,0,0,0,1,1,1,1; no word lost or duplicated.
- ready_i held low for 10 cycles after the first word. Required: data_o is constant and no further fifo_read_o pulses occur; after ready_i rises, the sequence continues intact.
- Assert rst in WAIT with valid_o=1. Required: all outputs are 0 on the following cycle; after release, the arbiter restarts from ch0.
- enable_i=0 from reset, with data present. Required: busy_o=0 and no read pulses. Raise enable_i: the first word appears 2 cycles later.
- With FLO_RX_ARB_URGENT_EN: ch1 locs=12300 while ch0 is valid and rr_ptr=0. Required: ch1 is granted first and drains past 4 words until its locs fall below 12288.
